// File: rtl/npu_result_reader.sv
// npu_result_reader: snapshots the PE accumulators on a capture pulse, then
// streams requantized results (shift, optional ReLU, saturate) over a
// valid/ready port, one word per handshake, tagged with the PE index.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for capture; shadow registers hold the last snapshot
// SEND  | presenting shadow[idx] on the output port until accepted
// DONE  | one-cycle completion pulse, then back to IDLE
module npu_result_reader #(
    parameter int N     = 10,
    parameter int W_ACC = 16,
    parameter int W_OUT = 8,
    parameter int IDX_W = 4,
    parameter int SH_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture,
    input  logic [N*W_ACC-1:0] pe_result,
    input  logic [SH_W-1:0]    shift_amt,
    input  logic               relu_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_OUT-1:0]   out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               busy,
    output logic               done,
    output logic               capture_err,
    input  logic               clear_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturation bounds expressed at accumulator width
    localparam logic signed [W_ACC-1:0] OUT_MAX =
        {{(W_ACC-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] OUT_MIN =
        {{(W_ACC-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    state_t                  state;
    state_t                  state_nxt;
    logic signed [W_ACC-1:0] shadow [N];
    logic [SH_W-1:0]         sh_q;
    logic                    relu_q;
    logic [IDX_W-1:0]        idx;
    logic                    last_word;
    logic                    accept;
    logic                    start;
    logic signed [W_ACC-1:0] shifted;
    logic signed [W_ACC-1:0] rectified;
    logic [W_OUT-1:0]        saturated;

    assign last_word = (idx == IDX_W'(N - 1));
    assign accept    = (state == SEND) && out_ready;
    assign start     = (state == IDLE) && capture;

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (capture) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Snapshot of accumulators and requant settings, taken only from IDLE
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
            end
            sh_q   <= '0;
            relu_q <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < N; i++) begin
                shadow[i] <= pe_result[i*W_ACC +: W_ACC];
            end
            sh_q   <= shift_amt;
            relu_q <= relu_en;
        end
    end

    // Readout index: cleared on a fresh capture, advanced on each non-final accept
    always_ff @(posedge clk) begin
        if (rst_n) begin
            idx <= '0;
        end else if (start) begin
            idx <= '0;
        end else if (accept && !last_word) begin
            idx <= idx + 1'b1;
        end
    end

    // Sticky error for captures outside IDLE; a new error wins over clear
    always_ff @(posedge clk) begin
        if (rst_n) begin
            capture_err <= 1'b0;
        end else if (capture && (state != IDLE)) begin
            capture_err <= 1'b1;
        end else if (clear_err) begin
            capture_err <= 1'b0;
        end
    end

    // Requantization: arithmetic shift, optional ReLU, signed saturation
    always_comb begin
        shifted   = shadow[idx] >>> sh_q;
        rectified = shifted;
        if (relu_q && (shifted < 0)) begin
            rectified = '0;
        end
        saturated = rectified[W_OUT-1:0];
        if (rectified > OUT_MAX) begin
            saturated = OUT_MAX[W_OUT-1:0];
        end else if (rectified < OUT_MIN) begin
            saturated = OUT_MIN[W_OUT-1:0];
        end
    end

    // Output port is zero outside SEND
    always_comb begin
        out_data = '0;
        out_idx  = '0;
        if (state == SEND) begin
            out_data = saturated;
            out_idx  = idx;
        end
    end

endmodule

// File: doc/npu_result_reader.md
Name: npu_result_reader

Overview:
- Read-side counterpart to the NPU scheduler's buffer-write path: drains the PE array's accumulator results after a compute pass.
- On a capture pulse (issued at the scheduler's WRITE_BACK), snapshots all N PE accumulators into shadow registers.
- Requantizes each value (arithmetic shift, optional ReLU, signed saturation).
- Streams the results out one per handshake over a valid/ready port, tagged with the PE index.

Parameters:
- N, 10, number of PEs / results per capture
- W_ACC, 16, signed PE accumulator width
- W_OUT, 8, signed output word width
- IDX_W, 4, PE index width; must satisfy IDX_W >= $clog2(N)
- SH_W, 4, requantization shift-amount width

Ports:
- clk  in  1  work clock, rising edge
- rst_n  in  1  reset, synchronous, active-high (1 = reset)
- capture  in  1  one-cycle pulse: snapshot pe_result and start readout
- pe_result  in  N*W_ACC  flattened accumulators; PE i at bits [i*W_ACC +: W_ACC], signed
- shift_amt  in  SH_W  arithmetic right-shift amount, unsigned
- relu_en  in  1  clamp negative results to 0
- out_valid  out  1  out_data/out_idx valid
- out_ready  in  1  downstream accepts word
- out_data  out  W_OUT  requantized signed result
- out_idx  out  IDX_W  PE index of out_data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last word is accepted
- capture_err  out  1  sticky: capture arrived while not IDLE
- clear_err  in  1  clears capture_err

Behaviour:
- Reset (rst_n=1 at a clk edge) forces:
  - state=IDLE, idx=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0, capture_err=0.
  - Shadow registers reset to 0.
  - Reset mid-readout abandons the transfer; no done pulse is generated.
- FSM states: IDLE, SEND, DONE.
  - IDLE: on capture=1, latch all N pe_result lanes, shift_amt and relu_en into shadow registers; set idx=0; go to SEND.
  - SEND: out_valid=1. On out_valid&&out_ready: if idx==N-1, go to DONE; else idx<=idx+1 and stay in SEND.
  - DONE: done=1 for exactly this one cycle, out_valid=0; return to IDLE unconditionally.
- Latency:
  - capture at edge t gives out_valid=1 with out_idx=0 in the cycle after t.
  - With out_ready held at 1, word k is accepted at edge t+1+k.
  - done is high in the cycle after the accept of word N-1; busy falls in the following cycle.
  - Full drain takes N+2 cycles from capture to IDLE.
- Handshake:
  - out_valid never drops without an accept.
  - out_data and out_idx stay stable while out_valid=1 && out_ready=0.
  - out_ready has no effect outside SEND.
- Datapath:
  - out_data is combinational from the registered shadow[idx], latched shift and latched relu. The pe_result, shift_amt and relu_en inputs are ignored after capture.
  - Step 1: s = shadow[idx] >>> shift (arithmetic shift, sign-filling; shift >= W_ACC yields 0 or -1).
  - Step 2: if relu is set and s < 0, then s = 0.
  - Step 3: saturate to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
  - out_data = 0 outside SEND. out_idx = idx in SEND, 0 otherwise.
- capture outside IDLE (in SEND or DONE):
  - The capture is ignored; shadow registers and idx are unchanged.
  - capture_err is set to 1.
- capture_err:
  - Cleared by clear_err=1.
  - If clear_err and an erroneous capture occur in the same cycle, set wins (capture_err=1).
- capture in the same cycle as the final accept: the FSM is in SEND, so the capture is an error. Upstream must wait for done.
- The pe_result sample is the value present at the capture edge, so the PE outputs must be settled by then.

Test Plan:
- Saturation, out_ready tied 1, shift=0, relu=0:
  - Stimulus: pe_result = [300, -300, 127, 128, -128, -129, 5, -5, 0, 32767], one capture pulse.
  - Required response: out_data = 127, -128, 127, 127, -128, -128, 5, -5, 0, 127 on consecutive cycles; out_idx = 0..9; done exactly 1 cycle later; busy low after 12 cycles total.
- Shift and ReLU, shift=2, relu=1:
  - Stimulus: pe_result = [300, -300, 1000, 3, -5, ...].
  - Required response: out_data = 75, 0, 127, 0, 0.
  - Companion run with shift=1, relu=0: -5 produces -3.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,... pseudo-randomly.
  - Required response: exactly 10 accepts, indices 0..9 in order, no gaps or duplicates; out_data/out_idx unchanged on every stalled cycle.
- Input isolation and error flag:
  - Stimulus: after capture, change pe_result/shift_amt/relu_en and pulse capture again during SEND.
  - Required response: the stream still reflects the first snapshot; capture_err=1 and stays 1.
  - Follow-up: clear_err pulse gives capture_err=0; simultaneous clear_err + bad capture gives capture_err=1.
- Reset mid-readout:
  - Stimulus: assert rst_n for 1 cycle after 4 accepts.
  - Required response: next cycle out_valid=0, busy=0, done never pulses; a new capture restarts at out_idx=0.
- Back-to-back passes:
  - Stimulus: capture in the first IDLE cycle after done.
  - Required response: accepted, no capture_err, second stream is correct.
